w5300_bus_master: RTL and testbench
===================================

# w5300_bus_master

Parallel-bus master that turns register access requests from the UART command/control FSM into W5300 host-bus cycles (cs/rd/wr strobes, 10-bit address, 8-bit bidirectional data). It sits directly between the command logic and the W5300 pins. It also synchronises the chip's active-low interrupt for the control FSM. Each request is a single byte access, or a 16-bit register access issued as two back-to-back byte cycles.

## Interface
Parameters:
- SETUP_CYC, 2: cycles cs/addr/wdata are valid before the rd/wr strobe (legal 1..15).
- STROBE_CYC, 3: cycles rd or wr is held low (legal 1..15).
- HOLD_CYC, 1: cycles cs/addr/wdata are held after the strobe rises (legal 1..15).

Ports:
- clk  in  1  system clock (27 MHz).
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_word  in  1  1 = 16-bit access (two byte cycles), 0 = single byte.
- req_addr  in  10  byte address; req_addr[0] is ignored when req_word = 1.
- req_wdata  in  16  write data; a byte access uses [7:0].
- rsp_valid  out  1  one-cycle pulse when the request completes (read or write).
- rsp_rdata  out  16  read data, valid with rsp_valid; a byte read returns {8'h00, byte}.
- addr  out  10  W5300 address bus.
- data_bus  inout  8  W5300 data bus; driven only during write cycles.
- cs  out  1  chip select, active low.
- rd  out  1  read strobe, active low.
- wr  out  1  write strobe, active low.
- int_n  in  1  W5300 interrupt, active low, asynchronous.
- irq  out  1  synchronised interrupt, active high.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, GAP.
- **IDLE:** req_ready = 1. On req_valid, latch write, word, addr and wdata, then go to SETUP.
  - Word access: first byte cycle uses {addr[9:1],1'b0} with wdata[15:8] (high byte at the even address). Second byte cycle uses {addr[9:1],1'b1} with wdata[7:0].
  - Byte access: uses addr as given, with wdata[7:0].
- **SETUP (SETUP_CYC cycles):** cs = 0; addr valid; data_bus driven if write; rd = wr = 1.
- **STROBE (STROBE_CYC cycles):** rd = 0 for a read, wr = 0 for a write.
  - Read data is captured from data_bus on the clock edge that ends the last STROBE cycle.
  - In a word read, the first byte goes to rsp_rdata[15:8] and the second to [7:0].
- **HOLD (HOLD_CYC cycles):** rd = wr = 1; cs = 0; addr and write data held.
- After HOLD:
  - If the second byte of a word is pending, go to GAP: one cycle with cs = 1, bus released, addr updated to the odd address. Then go to SETUP.
  - Otherwise go to IDLE with rsp_valid = 1 for that one cycle.
- A new request may be accepted in the same cycle rsp_valid is high.
- req_ready = 0 in every state except IDLE. A req_valid asserted while busy is held off, never dropped and never merged.
- Strobes are registered outputs: no glitches, and rd and wr are never low together. cs is low whenever rd or wr is low.
- irq: int_n passes through a 2-flop synchroniser; irq = ~synchronised value.
- Counters are 4 bits, loaded with PARAM-1 and decremented. Parameter value 0 is illegal, with no defined behaviour.

## Timing
- Reset values: cs = rd = wr = 1, addr = 0, data_bus = Z, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, irq = 0. The synchroniser flops reset to 1.
- Let cycle 0 be the accept edge.
  - cs falls at cycle 1.
  - The strobe falls at cycle 1+SETUP_CYC.
  - The strobe rises at cycle 1+SETUP_CYC+STROBE_CYC.
  - cs rises at cycle 1+SETUP_CYC+STROBE_CYC+HOLD_CYC, and rsp_valid is high in that same cycle.
- Byte latency is L = 1+S+T+H cycles (7 with defaults).
- Word latency is 2L = 14 cycles with defaults, including the GAP cycle.
- Strobe width is STROBE_CYC×37 ns = 111 ns with defaults, which meets the W5300 minimum of 65 ns.
- Reset asserted mid-cycle: at the next edge all strobes go high, cs goes high, the bus is released and the state returns to IDLE. No rsp_valid is issued.
- irq latency: 2–3 cycles after an int_n edge.

## Test plan
- Byte write addr 10'h1A5, wdata 16'h003C, default params:
  - cs low for cycles 1–6, wr low for cycles 3–5, data_bus = 8'h3C for cycles 1–6.
  - rsp_valid pulses at cycle 7; rd never toggles.
- Word read addr 10'h004, bus model returns 8'h00 then 8'hFF:
  - two cs windows separated by one cs-high cycle, at addr 10'h004 then 10'h005.
  - rsp_rdata = 16'h00FF; data_bus is never driven by the DUT.
- Word write addr 10'h003 (odd), wdata 16'h0010:
  - byte cycles at 10'h002 with 8'h00, then 10'h003 with 8'h10.
  - rsp_valid comes 14 cycles after accept.
- Back-to-back: req_valid held high for 3 byte reads:
  - req_ready is low while busy.
  - requests are accepted exactly on the rsp_valid cycles, and 3 rsp_valid pulses are seen with no lost request.
- Reset mid-strobe: rst_n low for 1 cycle during STROBE of a write:
  - next edge gives cs = rd = wr = 1, data_bus = Z, no rsp_valid, req_ready = 1.
- int_n held low for 10 cycles then high:
  - irq rises 2–3 cycles after the falling edge and falls 2–3 cycles after the rising edge.
  - Repeat with SETUP_CYC = 1, STROBE_CYC = 1, HOLD_CYC = 1: byte latency = 4.

Source files
------------

// File: rtl/w5300_bus_master_if.sv
// Request/response handshake between the command FSM and the W5300 bus master.
interface w5300_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_word;
  logic [9:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_word, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_word, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/w5300_bus_master.sv
// W5300 host-bus master: byte or 16-bit register accesses as timed cs/rd/wr cycles,
// plus a 2-flop synchroniser for the chip's active-low interrupt.
module w5300_bus_master #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  w5300_bus_master_if.slave    req,
  output logic [9:0]           addr,
  inout  tri   [7:0]           data_bus,
  output logic                 cs,
  output logic                 rd,
  output logic                 wr,
  input  logic                 int_n,
  output logic                 irq
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_t;

  localparam logic [3:0] S_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] T_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] H_LD = 4'(HOLD_CYC - 1);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        second, second_d;
  logic        is_wr, is_word;
  logic [7:0]  lo_byte, dout;
  logic        oe;
  logic        accept, write_d, capture, rsp_d;
  logic        cs_d, rd_d, wr_d, oe_d;
  logic [1:0]  int_sync;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    second_d = second;
    rsp_d    = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: if (req.req_valid) begin
        state_d  = SETUP;
        cnt_d    = S_LD;
        second_d = 1'b0;
      end
      SETUP: if (cnt == '0) begin
        state_d = STROBE;
        cnt_d   = T_LD;
      end else cnt_d = cnt - 4'd1;
      STROBE: if (cnt == '0) begin
        state_d = HOLD;
        cnt_d   = H_LD;
        capture = 1'b1;
      end else cnt_d = cnt - 4'd1;
      HOLD: if (cnt == '0) begin
        if (is_word && !second) state_d = GAP;
        else begin
          state_d = IDLE;
          rsp_d   = 1'b1;
        end
      end else cnt_d = cnt - 4'd1;
      GAP: begin
        state_d  = SETUP;
        cnt_d    = S_LD;
        second_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Pin values are decoded from the next state so every strobe leaves a flop.
    accept  = (state == IDLE) && req.req_valid;
    write_d = accept ? req.req_write : is_wr;
    cs_d    = !(state_d inside {SETUP, STROBE, HOLD});
    rd_d    = !((state_d == STROBE) && !write_d);
    wr_d    = !((state_d == STROBE) && write_d);
    oe_d    = write_d && !cs_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      second        <= 1'b0;
      is_wr         <= 1'b0;
      is_word       <= 1'b0;
      lo_byte       <= '0;
      dout          <= '0;
      oe            <= 1'b0;
      addr          <= '0;
      cs            <= 1'b1;
      rd            <= 1'b1;
      wr            <= 1'b1;
      req.rsp_valid <= 1'b0;
      req.rsp_rdata <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      second        <= second_d;
      cs            <= cs_d;
      rd            <= rd_d;
      wr            <= wr_d;
      oe            <= oe_d;
      req.rsp_valid <= rsp_d;
      if (accept) begin
        is_wr   <= req.req_write;
        is_word <= req.req_word;
        lo_byte <= req.req_wdata[7:0];
        addr    <= req.req_word ? {req.req_addr[9:1], 1'b0} : req.req_addr;
        dout    <= req.req_word ? req.req_wdata[15:8] : req.req_wdata[7:0];
      end
      if (state == HOLD && state_d == GAP) begin
        addr[0] <= 1'b1;
        dout    <= lo_byte;
      end
      if (capture && !is_wr) begin
        if (!is_word)     req.rsp_rdata       <= {8'h00, data_bus};
        else if (!second) req.rsp_rdata[15:8] <= data_bus;
        else              req.rsp_rdata[7:0]  <= data_bus;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) int_sync <= 2'b11;
    else        int_sync <= {int_sync[0], int_n};
  end

  assign irq           = ~int_sync[1];
  assign req.req_ready = (state == IDLE);
  assign data_bus      = oe ? dout : 'z;

endmodule

// File: tb/tb_w5300_bus_master.sv
// Bench for w5300_bus_master: per-cycle pin model derived from cycle offsets, directed and random requests.
module tb_w5300_bus_master;
  localparam int unsigned S  = 2;
  localparam int unsigned T  = 3;
  localparam int unsigned H  = 1;
  localparam int unsigned PH = S + T + H;
  localparam int unsigned L  = PH + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, int_n, irq, cs, rd, wr;
  logic [9:0] addr;
  tri   [7:0] data_bus;
  logic [7:0] tb_byte;
  w5300_bus_master_if rq();

  logic rst2, irq2, cs2, rd2, wr2;
  logic [9:0] addr2;
  tri   [7:0] data_bus2;
  w5300_bus_master_if rq2();

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data_bus[g]);
    pullup (data_bus2[g]);
  end
  assign data_bus  = rd  ? 8'bz : tb_byte;
  assign data_bus2 = rd2 ? 8'bz : 8'hA7;

  w5300_bus_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
    .clk(clk), .rst_n(rst_n), .req(rq), .addr(addr), .data_bus(data_bus),
    .cs(cs), .rd(rd), .wr(wr), .int_n(int_n), .irq(irq));

  w5300_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut2 (
    .clk(clk), .rst_n(rst2), .req(rq2), .addr(addr2), .data_bus(data_bus2),
    .cs(cs2), .rd(rd2), .wr(wr2), .int_n(1'b1), .irq(irq2));

  int unsigned n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction described by its cycle offset k since accept.
  bit          m_active = 0, m_wr = 0, m_word = 0, acc = 0;
  int unsigned m_k = 0, m_n = 0;
  logic [9:0]  m_a0 = '0, m_last_addr = '0;
  logic [7:0]  m_b0 = '0, m_b1 = '0;
  bit          s1 = 1, s2 = 1;

  bit          nx_valid = 0, nx_write = 0, nx_word = 0, nx_rst = 0, nx_int = 1;
  logic [9:0]  nx_addr = '0;
  logic [15:0] nx_wdata = '0;
  logic [7:0]  nx_rb0 = '0, nx_rb1 = '0;

  typedef struct {
    logic cs, rd, wr, rsp, ready;
    logic [9:0] addr;
    logic [7:0] bus, pbyte;
  } exp_t;

  function automatic exp_t model_now();
    exp_t e;
    int unsigned j;
    bit ph, gap;
    e.cs = 1; e.rd = 1; e.wr = 1; e.rsp = 0; e.ready = 1;
    e.addr = m_last_addr; e.bus = 8'hFF; e.pbyte = m_b0;
    if (m_active) begin
      ph      = m_word && (m_k > PH);
      e.addr  = ph ? {m_a0[9:1], 1'b1} : m_a0;
      e.pbyte = ph ? m_b1 : m_b0;
      if (m_k == m_n) e.rsp = 1;
      else begin
        e.ready = 0;
        gap = m_word && (m_k == PH + 1);
        j   = ph ? m_k - PH - 1 : m_k;
        if (!gap) begin
          e.cs = 0;
          if (m_wr) e.bus = e.pbyte;
          if (j > S && j <= S + T) begin
            if (m_wr) e.wr = 0;
            else begin
              e.rd  = 0;
              e.bus = e.pbyte;
            end
          end
        end
      end
    end
    return e;
  endfunction

  task automatic check_now();
    exp_t e;
    e = model_now();
    chk("cs", cs, e.cs);
    chk("rd", rd, e.rd);
    chk("wr", wr, e.wr);
    chk("addr", addr, e.addr);
    chk("data_bus", data_bus, e.bus);
    chk("req_ready", rq.req_ready, e.ready);
    chk("rsp_valid", rq.rsp_valid, e.rsp);
    chk("irq", irq, !s2);
    if (e.rsp && !m_wr)
      chk("rsp_rdata", rq.rsp_rdata, m_word ? {m_b0, m_b1} : {8'h00, m_b0});
    m_last_addr = e.addr;
  endtask

  task automatic model_step();
    bit ready;
    ready = !m_active || (m_k == m_n);
    acc   = 0;
    if (!nx_rst) begin
      m_active = 0; m_last_addr = '0; s1 = 1; s2 = 1;
    end else begin
      s2 = s1; s1 = nx_int;
      if (m_active) begin
        if (m_k == m_n) m_active = 0;
        else m_k++;
      end
      if (ready && nx_valid) begin
        acc = 1; m_active = 1; m_k = 1;
        m_wr = nx_write; m_word = nx_word;
        m_a0 = nx_word ? {nx_addr[9:1], 1'b0} : nx_addr;
        m_n  = nx_word ? 2 * L : L;
        if (nx_write) begin
          m_b0 = nx_word ? nx_wdata[15:8] : nx_wdata[7:0];
          m_b1 = nx_wdata[7:0];
        end else begin
          m_b0 = nx_rb0; m_b1 = nx_rb1;
        end
      end
    end
    rst_n        = nx_rst;
    int_n        = nx_int;
    rq.req_valid = nx_valid;
    rq.req_write = nx_write;
    rq.req_word  = nx_word;
    rq.req_addr  = nx_addr;
    rq.req_wdata = nx_wdata;
    tb_byte      = model_now().pbyte;
  endtask

  task automatic step();
    @(negedge clk);
    check_now();
    model_step();
  endtask

  task automatic issue(input bit w, input bit wd, input logic [9:0] a,
                       input logic [15:0] d, input logic [7:0] r0, input logic [7:0] r1);
    bit got;
    nx_valid = 1; nx_write = w; nx_word = wd; nx_addr = a; nx_wdata = d;
    nx_rb0 = r0; nx_rb1 = r1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = acc;
    end
    if (!got) chk("accept_timeout", 0, 1);
    nx_valid = 0;
  endtask

  initial begin
    int unsigned ncs, nwr, nrd, lat, nacc, nrsp, ncoin, nwin;
    logic [15:0] rdat;
    logic prev_cs;

    rst_n = 0; int_n = 1; tb_byte = '0; rst2 = 0;
    rq.req_valid = 0; rq.req_write = 0; rq.req_word = 0; rq.req_addr = '0; rq.req_wdata = '0;
    rq2.req_valid = 0; rq2.req_write = 0; rq2.req_word = 0; rq2.req_addr = '0; rq2.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs", cs, 1); chk("rst_rd", rd, 1); chk("rst_wr", wr, 1);
    chk("rst_addr", addr, 0); chk("rst_ready", rq.req_ready, 1);
    chk("rst_rsp_valid", rq.rsp_valid, 0); chk("rst_rdata", rq.rsp_rdata, 0);
    chk("rst_irq", irq, 0); chk("rst_bus", data_bus, 8'hFF);
    nx_rst = 1; rst2 = 1;
    step();

    // Byte write 1A5 <- 3C
    issue(1, 0, 10'h1A5, 16'h003C, 8'h00, 8'h00);
    ncs = 0; nwr = 0; nrd = 0; lat = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (!cs) ncs++;
      if (!wr) nwr++;
      if (!rd) nrd++;
      if (c == 1) chk("bw_bus_c1", data_bus, 8'h3C);
      if (c == 3) chk("bw_wr_c3", wr, 0);
      if (rq.rsp_valid && lat == 0) lat = c;
    end
    chk("bw_cs_cycles", ncs, 6); chk("bw_wr_cycles", nwr, 3);
    chk("bw_rd_cycles", nrd, 0); chk("bw_latency", lat, 7);

    // Word read 004 -> 00, FF
    issue(0, 1, 10'h004, 16'h0000, 8'h00, 8'hFF);
    lat = 0; nwin = 0; prev_cs = 1; rdat = '1;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (!cs && prev_cs) nwin++;
      prev_cs = cs;
      if (c == 1) chk("wr_addr_c1", addr, 10'h004);
      if (c == 8) chk("wr_addr_c8", addr, 10'h005);
      if (rq.rsp_valid && lat == 0) begin lat = c; rdat = rq.rsp_rdata; end
    end
    chk("wrd_windows", nwin, 2); chk("wrd_latency", lat, 14); chk("wrd_rdata", rdat, 16'h00FF);

    // Word write at odd address 003 <- 0010
    issue(1, 1, 10'h003, 16'h0010, 8'h00, 8'h00);
    lat = 0;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c == 1) begin chk("ww_addr_c1", addr, 10'h002); chk("ww_bus_c1", data_bus, 8'h00); end
      if (c == 8) begin chk("ww_addr_c8", addr, 10'h003); chk("ww_bus_c8", data_bus, 8'h10); end
      if (rq.rsp_valid && lat == 0) lat = c;
    end
    chk("ww_latency", lat, 14);

    // Three byte reads with req_valid held high
    nx_valid = 1; nx_write = 0; nx_word = 0; nx_addr = 10'h010; nx_rb0 = 8'h11;
    nacc = 0; nrsp = 0; ncoin = 0;
    for (int c = 0; c < 60 && nrsp < 3; c++) begin
      step();
      if (rq.rsp_valid) nrsp++;
      if (acc) begin
        if (rq.rsp_valid) ncoin++;
        nacc++;
        nx_addr = nx_addr + 10'd1; nx_rb0 = nx_rb0 + 8'h11;
        if (nacc == 3) nx_valid = 0;
      end
    end
    nx_valid = 0;
    chk("b2b_accepts", nacc, 3); chk("b2b_rsp", nrsp, 3); chk("b2b_acc_on_rsp", ncoin, 2);

    // Reset during the strobe of a write
    issue(1, 0, 10'h2F0, 16'h00A5, 8'h00, 8'h00);
    for (int c = 1; c <= S + 1; c++) step();
    chk("mid_wr_low", wr, 0);
    nx_rst = 0;
    step();
    nx_rst = 1;
    step();
    chk("mr_cs", cs, 1); chk("mr_wr", wr, 1); chk("mr_rd", rd, 1);
    chk("mr_bus", data_bus, 8'hFF); chk("mr_ready", rq.req_ready, 1); chk("mr_rsp", rq.rsp_valid, 0);
    nrsp = 0;
    for (int c = 0; c < 10; c++) begin step(); if (rq.rsp_valid) nrsp++; end
    chk("mr_no_rsp", nrsp, 0);

    // Interrupt low for 10 cycles
    nx_int = 0; step();
    lat = 0;
    for (int c = 1; c <= 9; c++) begin step(); if (irq && lat == 0) lat = c; end
    chk("irq_rise_ok", (lat >= 2 && lat <= 3), 1);
    nx_int = 1; step();
    lat = 0;
    for (int c = 1; c <= 6; c++) begin step(); if (!irq && lat == 0) lat = c; end
    chk("irq_fall_ok", (lat >= 2 && lat <= 3), 1);

    // Random traffic, held-off requests, interrupt toggles and occasional resets
    for (int it = 0; it < 1500; it++) begin
      if (!nx_valid && $urandom_range(0, 9) < 4) begin
        nx_valid = 1; nx_write = 1'($urandom); nx_word = 1'($urandom);
        nx_addr = 10'($urandom); nx_wdata = 16'($urandom);
        nx_rb0 = 8'($urandom); nx_rb1 = 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) nx_int = !nx_int;
      nx_rst = ($urandom_range(0, 299) != 0);
      if (!nx_rst) nx_valid = 0;
      step();
      if (acc) nx_valid = 0;
      nx_rst = 1;
    end
    nx_valid = 0;
    for (int c = 0; c < 30; c++) step();

    // Minimum timing instance: byte read then byte write
    @(negedge clk);
    rq2.req_valid = 1; rq2.req_write = 0; rq2.req_word = 0; rq2.req_addr = 10'h3FF;
    @(negedge clk);
    rq2.req_valid = 0;
    lat = 0; nrd = 0; rdat = '0;
    for (int c = 1; c <= 8; c++) begin
      if (!rd2) nrd++;
      if (rq2.rsp_valid && lat == 0) begin lat = c; rdat = rq2.rsp_rdata; end
      @(negedge clk);
    end
    chk("p1_rd_latency", lat, 4); chk("p1_rd_cycles", nrd, 1); chk("p1_rdata", rdat, 16'h00A7);
    rq2.req_valid = 1; rq2.req_write = 1; rq2.req_addr = 10'h155; rq2.req_wdata = 16'hBE42;
    @(negedge clk);
    rq2.req_valid = 0;
    lat = 0; ncs = 0;
    for (int c = 1; c <= 8; c++) begin
      if (!cs2) ncs++;
      if (c == 2) begin chk("p1_wr_low", wr2, 0); chk("p1_wr_bus", data_bus2, 8'h42); end
      if (rq2.rsp_valid && lat == 0) lat = c;
      @(negedge clk);
    end
    chk("p1_wr_latency", lat, 4); chk("p1_cs_cycles", ncs, 3); chk("p1_irq", irq2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
